memory_bridge: RTL and testbench

Converts the CPU's byte-addressed, variable-size memory request interface (byte/half/word, any alignment) into accesses on a 32-bit word-wide synchronous RAM with byte enables. It sits directly downstream of the CPU memory port and upstream of a `word_ram` instance. Misaligned accesses that straddle a word boundary are split into two RAM transactions. Out-of-range requests are flagged.

---
 rtl/memory_bus_pkg.sv | 43 ++++
 rtl/memory_bridge_if.sv | 30 +++
 rtl/word_ram.sv | 31 +++
 rtl/memory_bridge.sv | 153 +++++++++++++++
 tb/tb_memory_bridge.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/memory_bus_pkg.sv
// Shared definitions for the CPU memory port and the memory bridge.
// Holds access-size and operation encodings (also used by the CPU), the
// bridge state enum, and small decode helpers for byte count and lane mask.
package memory_bus_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ACCESS_LO = 3'd1,
    ST_ACCESS_HI = 3'd2,
    ST_FINISH    = 3'd3,
    ST_ERROR     = 3'd4,
    ST_DONE      = 3'd5
  } bridge_state_t;

  // Number of bytes moved by an access; size code 3 behaves as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

  // Byte lanes touched across two consecutive words: [3:0] low, [7:4] high.
  function automatic logic [7:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] offset);
    logic [7:0] base;
    case (size)
      SIZE_BYTE: base = 8'h01;
      SIZE_HALF: base = 8'h03;
      default:   base = 8'h0F;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/memory_bridge_if.sv
// CPU-side memory request port of the memory bridge.
// Handshake: the CPU raises memory_enable with all request fields stable and
// holds them until it sees memory_ready; it then drops memory_enable, and the
// bridge drops memory_ready after the first edge that samples enable low.
// bus_error is a one-cycle pulse coinciding with the first ready cycle of an
// out-of-range request.
//   master : CPU side   (drives request fields, receives data/ready/error)
//   slave  : bridge side
interface memory_bridge_if;
  logic        memory_enable;
  logic        memory_operation;
  logic [1:0]  memory_data_size;
  logic [31:0] memory_address;
  logic [31:0] memory_data_out;
  logic [31:0] memory_data_in;
  logic        memory_ready;
  logic        bus_error;

  modport master (
    output memory_enable, memory_operation, memory_data_size,
           memory_address, memory_data_out,
    input  memory_data_in, memory_ready, bus_error
  );

  modport slave (
    input  memory_enable, memory_operation, memory_data_size,
           memory_address, memory_data_out,
    output memory_data_in, memory_ready, bus_error
  );
endinterface

// File: rtl/word_ram.sv
// 32-bit word-wide synchronous RAM with per-byte write enables.
// Ports: clock; enable/write_enable/byte_enable/address/write_data request;
// read_data valid the cycle after a read with enable high.
module word_ram #(
  parameter int ram_size = 65536,
  localparam int AW = $clog2(ram_size / 4)
) (
  input  logic          clock,
  input  logic          enable,
  input  logic          write_enable,
  input  logic [3:0]    byte_enable,
  input  logic [AW-1:0] address,
  input  logic [31:0]   write_data,
  output logic [31:0]   read_data
);

  logic [31:0] mem [ram_size / 4];

  always_ff @(posedge clock) begin
    if (enable) begin
      if (write_enable) begin
        for (int b = 0; b < 4; b++) begin
          if (byte_enable[b]) mem[address][8*b +: 8] <= write_data[8*b +: 8];
        end
      end else begin
        read_data <= mem[address];
      end
    end
  end

endmodule

// File: rtl/memory_bridge.sv
// Converts byte-addressed byte/half/word CPU requests of any alignment into
// accesses on a 32-bit word RAM with byte enables. Accesses straddling a word
// boundary become two RAM transactions; out-of-range requests are flagged
// with bus_error and make no RAM access.
// Ports: clock, reset (sync, active high); bus (CPU port, slave side);
// ram_* word RAM request outputs and ram_read_data input; state (FSM state).
module memory_bridge
  import memory_bus_pkg::*;
#(
  parameter int ram_size = 65536,
  localparam int AW = $clog2(ram_size / 4)
) (
  input  logic           clock,
  input  logic           reset,
  memory_bridge_if.slave bus,
  output logic [AW-1:0]  ram_address,
  output logic           ram_enable,
  output logic           ram_write_enable,
  output logic [3:0]     ram_byte_enable,
  output logic [31:0]    ram_write_data,
  input  logic [31:0]    ram_read_data,
  output bridge_state_t  state
);

  bridge_state_t state_q, state_next;

  logic          req_write;
  logic [1:0]    req_size;
  logic [AW+1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [31:0]   lo_word;
  logic [31:0]   data_in_q;
  logic          ready_q;
  logic          error_q;

  logic          accept;
  logic [32:0]   req_end;
  logic          out_of_range;
  logic [7:0]    mask8;
  logic          split;
  logic [AW-1:0] lo_index, hi_index;
  logic [63:0]   wr_image, rd_image;
  logic [31:0]   rd_shifted, rd_keep, rd_result;

  assign state                = state_q;
  assign bus.memory_ready     = ready_q;
  assign bus.bus_error        = error_q;
  assign bus.memory_data_in   = data_in_q;

  assign accept = (state_q == ST_IDLE) && bus.memory_enable && !ready_q;

  // Last byte address computed with a carry bit so high addresses cannot wrap
  // back into range; this also catches any nonzero bits above the RAM size.
  assign req_end = {1'b0, bus.memory_address}
                 + {30'b0, size_bytes(bus.memory_data_size)} - 33'd1;
  assign out_of_range = req_end >= 33'(ram_size);

  assign mask8    = lane_mask(req_size, req_addr[1:0]);
  assign split    = |mask8[7:4];
  assign lo_index = req_addr[AW+1:2];
  assign hi_index = lo_index + {{(AW-1){1'b0}}, 1'b1};

  assign wr_image = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};

  // In FINISH the live RAM output is the last word read: the high word of a
  // split access, otherwise the only word.
  assign rd_image   = split ? {ram_read_data, lo_word} : {32'b0, ram_read_data};
  assign rd_shifted = 32'(rd_image >> {req_addr[1:0], 3'b000});

  always_comb begin
    case (req_size)
      SIZE_BYTE: rd_keep = 32'h0000_00FF;
      SIZE_HALF: rd_keep = 32'h0000_FFFF;
      default:   rd_keep = 32'hFFFF_FFFF;
    endcase
  end

  assign rd_result = rd_shifted & rd_keep;

  always_comb begin
    state_next       = state_q;
    ram_enable       = 1'b0;
    ram_write_enable = 1'b0;
    ram_byte_enable  = 4'b0;
    ram_address      = '0;
    ram_write_data   = 32'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_next = out_of_range ? ST_ERROR : ST_ACCESS_LO;
      end
      ST_ACCESS_LO: begin
        ram_enable       = 1'b1;
        ram_write_enable = req_write;
        ram_address      = lo_index;
        ram_byte_enable  = req_write ? mask8[3:0] : 4'b0;
        ram_write_data   = req_write ? wr_image[31:0] : 32'b0;
        state_next       = split ? ST_ACCESS_HI : ST_FINISH;
      end
      ST_ACCESS_HI: begin
        ram_enable       = 1'b1;
        ram_write_enable = req_write;
        ram_address      = hi_index;
        ram_byte_enable  = req_write ? mask8[7:4] : 4'b0;
        ram_write_data   = req_write ? wr_image[63:32] : 32'b0;
        state_next       = ST_FINISH;
      end
      ST_FINISH: state_next = ST_DONE;
      ST_ERROR:  state_next = ST_DONE;
      ST_DONE: begin
        if (!bus.memory_enable) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      data_in_q <= 32'b0;
      req_write <= 1'b0;
      req_size  <= 2'b0;
      req_addr  <= '0;
      req_wdata <= 32'b0;
      lo_word   <= 32'b0;
    end else begin
      state_q <= state_next;
      error_q <= (state_q == ST_ERROR);
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            req_write <= (bus.memory_operation == OP_WRITE);
            req_size  <= bus.memory_data_size;
            req_addr  <= bus.memory_address[AW+1:0];
            req_wdata <= bus.memory_data_out;
          end
        end
        ST_ACCESS_HI: lo_word <= ram_read_data;
        ST_FINISH: begin
          ready_q <= 1'b1;
          if (!req_write) data_in_q <= rd_result;
        end
        ST_ERROR: ready_q <= 1'b1;
        ST_DONE: begin
          if (!bus.memory_enable) ready_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_bridge.sv
// Directed bench for memory_bridge with a word_ram beside it. RAM contents are
// set up through bridge writes; observed RAM accesses are compared against an
// expected access queue, latencies and read data against hand-computed values.
module tb_memory_bridge;
  import memory_bus_pkg::*;

  localparam int RAM_SIZE = 65536;
  localparam int AW = $clog2(RAM_SIZE / 4);

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  memory_bridge_if bus();

  logic [AW-1:0] ram_address;
  logic          ram_enable;
  logic          ram_write_enable;
  logic [3:0]    ram_byte_enable;
  logic [31:0]   ram_write_data;
  logic [31:0]   ram_read_data;
  bridge_state_t dut_state;

  memory_bridge #(.ram_size(RAM_SIZE)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .ram_address(ram_address), .ram_enable(ram_enable),
    .ram_write_enable(ram_write_enable), .ram_byte_enable(ram_byte_enable),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
    .state(dut_state)
  );

  word_ram #(.ram_size(RAM_SIZE)) u_ram (
    .clock(clock), .enable(ram_enable), .write_enable(ram_write_enable),
    .byte_enable(ram_byte_enable), .address(ram_address),
    .write_data(ram_write_data), .read_data(ram_read_data)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];

  function automatic logic [63:0] pack_acc(input logic we, input logic [3:0] be,
                                           input logic [31:0] addr, input logic [31:0] data);
    return {11'b0, we, be, addr[15:0], data};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (ram_enable)
      obs_q.push_back(pack_acc(ram_write_enable, ram_byte_enable, 32'(ram_address), ram_write_data));
    if (bus.bus_error) err_cnt++;
  end

  task automatic expect_acc(input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back(pack_acc(we, be, addr, data));
  endtask

  task automatic compare_accesses(input string tag);
    check({tag, "_acc_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_acc"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  // Starts at a negedge; edge 0 is the next posedge. Latency is the index of
  // the edge after which memory_ready is first seen high.
  task automatic txn(input string tag, input logic op, input logic [1:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int exp_lat, input int exp_err);
    int lat;
    obs_q.delete();
    err_cnt = 0;
    bus.memory_operation = op;
    bus.memory_data_size = size;
    bus.memory_address   = addr;
    bus.memory_data_out  = wdata;
    bus.memory_enable    = 1'b1;
    lat = -1;
    for (int e = 0; e < 20; e++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus.memory_ready) begin
        lat = e;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    bus.memory_enable = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check({tag, "_ready_drop"}, 64'(bus.memory_ready), 64'd0);
    check({tag, "_bus_error"}, 64'(err_cnt), 64'(exp_err));
    compare_accesses(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.memory_enable    = 1'b0;
    bus.memory_operation = OP_READ;
    bus.memory_data_size = SIZE_WORD;
    bus.memory_address   = 32'h0;
    bus.memory_data_out  = 32'h0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ready", 64'(bus.memory_ready), 64'd0);
    check("rst_bus_error", 64'(bus.bus_error), 64'd0);
    check("rst_data_in", 64'(bus.memory_data_in), 64'd0);
    check("rst_ram_enable", 64'(ram_enable), 64'd0);
    check("rst_state", 64'(dut_state), 64'(ST_IDLE));
    reset = 1'b0;

    // Aligned word write then read at 0x100 (word index 0x40).
    expect_acc(1'b1, 4'hF, 32'h40, 32'hDEADBEEF);
    txn("wr_word_100", OP_WRITE, SIZE_WORD, 32'h100, 32'hDEADBEEF, 2, 0);
    expect_acc(1'b0, 4'h0, 32'h40, 32'h0);
    txn("rd_word_100", OP_READ, SIZE_WORD, 32'h100, 32'h0, 2, 0);
    check("rd_word_100_data", 64'(bus.memory_data_in), 64'hDEADBEEF);

    // Split word read at 0x102 across words 0x40/0x41.
    expect_acc(1'b1, 4'hF, 32'h40, 32'h44332211);
    txn("wr_w40", OP_WRITE, SIZE_WORD, 32'h100, 32'h44332211, 2, 0);
    expect_acc(1'b1, 4'hF, 32'h41, 32'h88776655);
    txn("wr_w41", OP_WRITE, SIZE_WORD, 32'h104, 32'h88776655, 2, 0);
    expect_acc(1'b0, 4'h0, 32'h40, 32'h0);
    expect_acc(1'b0, 4'h0, 32'h41, 32'h0);
    txn("rd_split_102", OP_READ, SIZE_WORD, 32'h102, 32'h0, 3, 0);
    check("rd_split_102_data", 64'(bus.memory_data_in), 64'h66554433);

    // Byte write at 0x203 lands in lane 3 of word 0x80.
    expect_acc(1'b1, 4'b1000, 32'h80, 32'hA5000000);
    txn("wr_byte_203", OP_WRITE, SIZE_BYTE, 32'h203, 32'h000000A5, 2, 0);
    expect_acc(1'b0, 4'h0, 32'h80, 32'h0);
    txn("rd_byte_203", OP_READ, SIZE_BYTE, 32'h203, 32'h0, 2, 0);
    check("rd_byte_203_data", 64'(bus.memory_data_in), 64'h000000A5);

    // Split half write at 0x7: lane 3 of word 1, lane 0 of word 2.
    expect_acc(1'b1, 4'b1000, 32'h1, 32'hEF000000);
    expect_acc(1'b1, 4'b0001, 32'h2, 32'h000000BE);
    txn("wr_half_7", OP_WRITE, SIZE_HALF, 32'h7, 32'h0000BEEF, 3, 0);
    expect_acc(1'b0, 4'h0, 32'h1, 32'h0);
    expect_acc(1'b0, 4'h0, 32'h2, 32'h0);
    txn("rd_half_7", OP_READ, SIZE_HALF, 32'h7, 32'h0, 3, 0);
    check("rd_half_7_data", 64'(bus.memory_data_in), 64'h0000BEEF);

    // Last word of the RAM is in range.
    expect_acc(1'b1, 4'hF, 32'h3FFF, 32'h11223344);
    txn("wr_last_word", OP_WRITE, SIZE_WORD, 32'hFFFC, 32'h11223344, 2, 0);
    expect_acc(1'b0, 4'h0, 32'h3FFF, 32'h0);
    txn("rd_last_byte", OP_READ, SIZE_BYTE, 32'hFFFF, 32'h0, 2, 0);
    check("rd_last_byte_data", 64'(bus.memory_data_in), 64'h00000011);

    // Out-of-range: no RAM access, one error pulse, data_in unchanged.
    txn("err_rd_fffe", OP_READ, SIZE_WORD, 32'hFFFE, 32'h0, 1, 1);
    check("err_rd_fffe_data", 64'(bus.memory_data_in), 64'h00000011);
    txn("err_wr_high", OP_WRITE, SIZE_WORD, 32'h00FFFFFD, 32'h12345678, 1, 1);
    check("err_wr_high_data", 64'(bus.memory_data_in), 64'h00000011);
    txn("err_rd_half_ffff", OP_READ, SIZE_HALF, 32'hFFFF, 32'h0, 1, 1);

    // Reset during a split write: only the low word gets written.
    expect_acc(1'b1, 4'hF, 32'h42, 32'h12345678);
    txn("wr_w42", OP_WRITE, SIZE_WORD, 32'h108, 32'h12345678, 2, 0);
    bus.memory_operation = OP_WRITE;
    bus.memory_data_size = SIZE_WORD;
    bus.memory_address   = 32'h106;
    bus.memory_data_out  = 32'hCAFEF00D;
    bus.memory_enable    = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("mid_lo_enable", 64'(ram_enable), 64'd1);
    check("mid_lo_addr", 64'(ram_address), 64'h41);
    reset = 1'b1;
    bus.memory_enable = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("mid_rst_ram_enable", 64'(ram_enable), 64'd0);
    check("mid_rst_ram_we", 64'(ram_write_enable), 64'd0);
    check("mid_rst_ram_be", 64'(ram_byte_enable), 64'd0);
    check("mid_rst_ram_addr", 64'(ram_address), 64'd0);
    check("mid_rst_ram_wdata", 64'(ram_write_data), 64'd0);
    check("mid_rst_ready", 64'(bus.memory_ready), 64'd0);
    check("mid_rst_bus_error", 64'(bus.bus_error), 64'd0);
    check("mid_rst_data_in", 64'(bus.memory_data_in), 64'd0);
    check("mid_rst_state", 64'(dut_state), 64'(ST_IDLE));
    reset = 1'b0;
    repeat (3) @(negedge clock);
    expect_acc(1'b1, 4'b1100, 32'h41, 32'hF00D0000);
    compare_accesses("mid_rst");
    expect_acc(1'b0, 4'h0, 32'h42, 32'h0);
    txn("post_rst_rd_w42", OP_READ, SIZE_WORD, 32'h108, 32'h0, 2, 0);
    check("post_rst_rd_w42_data", 64'(bus.memory_data_in), 64'h12345678);
    expect_acc(1'b0, 4'h0, 32'h41, 32'h0);
    txn("post_rst_rd_w41", OP_READ, SIZE_WORD, 32'h104, 32'h0, 2, 0);
    check("post_rst_rd_w41_data", 64'(bus.memory_data_in), 64'hF00D6655);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
